// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add sequencer driving one external 1-bit full adder
//
// Adds two WIDTH-bit operands LSB first over WIDTH cycles using an external
// combinational FullAdder, then presents the sum and carry-out until the next
// completion. Optional macro SERIAL_ADD_SUB_EN adds sub_in for a-b.
//
// Ports:
//   clk_in      clock, rising edge
//   rst_in      synchronous reset, active-high
//   start_in    request, sampled only in IDLE
//   a_in/b_in   operands, captured on accepted start
//   c_in        initial carry, captured on accepted start
//   sub_in      (SERIAL_ADD_SUB_EN only) subtract select, captured on accepted start
//   busy_out    high while the serial add runs
//   done_out    one-cycle pulse when sum_out/carry_out have just been updated
//   sum_out     last completed sum
//   carry_out   last completed carry-out (in subtract mode: 1 = no borrow)
//   fa_x_out/fa_y_out/fa_cin_out   operand bits and carry to the FullAdder
//   fa_sum_in/fa_cout_in           FullAdder sum and carry results
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             start_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             c_in,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub_in,
`endif
   output logic             busy_out,
   output logic             done_out,
   output logic [WIDTH-1:0] sum_out,
   output logic             carry_out,
   output logic             fa_x_out,
   output logic             fa_y_out,
   output logic             fa_cin_out,
   input  logic             fa_sum_in,
   input  logic             fa_cout_in
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_sr_q;
   logic [WIDTH-1:0] b_sr_q;
   logic [WIDTH-1:0] s_sr_q;
   logic             cy_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
   logic             busy_q;
   logic             done_q;

   logic [WIDTH-1:0] b_cap_d;
   logic             cy_cap_d;
   logic [WIDTH-1:0] s_sr_d;

   // Subtraction is a + ~b + 1, so only the captured B and initial carry differ.
`ifdef SERIAL_ADD_SUB_EN
   assign b_cap_d  = sub_in ? ~b_in : b_in;
   assign cy_cap_d = sub_in ? 1'b1  : c_in;
`else
   assign b_cap_d  = b_in;
   assign cy_cap_d = c_in;
`endif

   // The sum bit arrives LSB first, so it enters at the top and shifts down.
   assign s_sr_d = {fa_sum_in, s_sr_q[WIDTH-1:1]};

   // Gated by state so the FullAdder inputs are quiet outside RUN.
   assign fa_x_out   = (state_q == ST_RUN) & a_sr_q[0];
   assign fa_y_out   = (state_q == ST_RUN) & b_sr_q[0];
   assign fa_cin_out = (state_q == ST_RUN) & cy_q;

   assign busy_out  = busy_q;
   assign done_out  = done_q;
   assign sum_out   = sum_q;
   assign carry_out = carry_q;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= ST_IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         s_sr_q  <= '0;
         cy_q    <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start_in) begin
                  a_sr_q  <= a_in;
                  b_sr_q  <= b_cap_d;
                  cy_q    <= cy_cap_d;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               s_sr_q <= s_sr_d;
               cy_q   <= fa_cout_in;
               a_sr_q <= a_sr_q >> 1;
               b_sr_q <= b_sr_q >> 1;
               cnt_q  <= cnt_q + CW'(1);
               if (cnt_q == LAST_BIT) begin
                  sum_q   <= s_sr_d;
                  carry_q <= fa_cout_in;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
